// File: rtl/mpt_walk_arbiter.sv
// Round-robin arbiter sharing one MPT walker between NUM_REQ requesters.
// One walk in flight; the walker permission is checked against the requested access type.
module mpt_walk_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned PLEN     = 56,
    parameter int unsigned SDID_LEN = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*PLEN-1:0] req_spa_i,
    input  logic [NUM_REQ*2-1:0]    req_access_i,
    input  logic [SDID_LEN-1:0]     req_sdid_i,
    output logic [NUM_REQ-1:0]      resp_valid_o,
    output logic                    resp_allow_o,
    output logic [1:0]              resp_perm_o,
    output logic                    resp_fault_o,
    output logic [2:0]              resp_fault_cause_o,
    output logic                    walk_valid_o,
    input  logic                    walk_ready_i,
    output logic [PLEN-1:0]         walk_spa_o,
    output logic [SDID_LEN-1:0]     walk_sdid_o,
    input  logic                    walk_done_i,
    input  logic [1:0]              walk_perm_i,
    input  logic                    walk_fault_i,
    input  logic [2:0]              walk_fault_cause_i,
    output logic                    busy_o
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e              state_q;
    logic [IW-1:0]       rr_q;
    logic [IW-1:0]       owner_q;
    logic [PLEN-1:0]     spa_q;
    logic [SDID_LEN-1:0] sdid_q;
    logic [1:0]          acc_q;
    logic                squash_q;
    logic                allow_q;
    logic [1:0]          perm_q;
    logic                fault_q;
    logic [2:0]          cause_q;

    logic                found;
    logic [IW-1:0]       win;
    logic [IW-1:0]       rr_d;
    logic                accept;

    function automatic logic allow_f(input logic [1:0] acc, input logic [1:0] perm);
        logic ok;
        case (acc)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (perm != 2'b00);
            2'b10:   ok = perm[1];
            default: ok = perm[0];
        endcase
        return ok;
    endfunction

    // First valid requester at or after rr_q, wrapping around.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid_i[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign accept = (state_q == IDLE) && found && !flush_i && !rst_i;
    assign rr_d   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[win] = 1'b1;
    end

    always_comb begin
        resp_valid_o = '0;
        if (state_q == RESP) resp_valid_o[owner_q] = 1'b1;
    end

    assign walk_valid_o       = (state_q == ISSUE) && !flush_i && !rst_i;
    assign walk_spa_o         = spa_q;
    assign walk_sdid_o        = sdid_q;
    assign busy_o             = (state_q != IDLE);
    assign resp_allow_o       = allow_q;
    assign resp_perm_o        = perm_q;
    assign resp_fault_o       = fault_q;
    assign resp_fault_cause_o = cause_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            owner_q  <= '0;
            spa_q    <= '0;
            sdid_q   <= '0;
            acc_q    <= '0;
            squash_q <= 1'b0;
            allow_q  <= 1'b0;
            perm_q   <= '0;
            fault_q  <= 1'b0;
            cause_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        spa_q   <= req_spa_i[win*PLEN +: PLEN];
                        acc_q   <= req_access_i[win*2 +: 2];
                        sdid_q  <= req_sdid_i;
                        owner_q <= win;
                        rr_q    <= rr_d;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush_i) state_q <= IDLE;
                    else if (walk_ready_i) state_q <= WAIT;
                end
                WAIT: begin
                    if (walk_done_i) begin
                        squash_q <= 1'b0;
                        if (flush_i || squash_q) begin
                            state_q <= IDLE;
                        end else begin
                            // A fault hides the permission and forces a deny.
                            fault_q <= walk_fault_i;
                            cause_q <= walk_fault_i ? walk_fault_cause_i : 3'b000;
                            perm_q  <= walk_fault_i ? 2'b00 : walk_perm_i;
                            allow_q <= !walk_fault_i && allow_f(acc_q, walk_perm_i);
                            state_q <= RESP;
                        end
                    end else if (flush_i) begin
                        squash_q <= 1'b1;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpt_walk_arbiter.sv
// Bench for mpt_walk_arbiter: permission table, hand-built corner sequences,
// then random traffic against a timeline-based arbitration model.
module tb_mpt_walk_arbiter;

    localparam int N  = 3;
    localparam int PL = 56;
    localparam int SL = 6;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*PL-1:0]   req_spa_i;
    logic [N*2-1:0]    req_access_i;
    logic [SL-1:0]     req_sdid_i;
    logic [N-1:0]      resp_valid_o;
    logic              resp_allow_o;
    logic [1:0]        resp_perm_o;
    logic              resp_fault_o;
    logic [2:0]        resp_fault_cause_o;
    logic              walk_valid_o;
    logic              walk_ready_i;
    logic [PL-1:0]     walk_spa_o;
    logic [SL-1:0]     walk_sdid_o;
    logic              walk_done_i;
    logic [1:0]        walk_perm_i;
    logic              walk_fault_i;
    logic [2:0]        walk_fault_cause_i;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    mpt_walk_arbiter #(.NUM_REQ(N), .PLEN(PL), .SDID_LEN(SL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_spa_i(req_spa_i), .req_access_i(req_access_i), .req_sdid_i(req_sdid_i),
        .resp_valid_o(resp_valid_o), .resp_allow_o(resp_allow_o),
        .resp_perm_o(resp_perm_o), .resp_fault_o(resp_fault_o),
        .resp_fault_cause_o(resp_fault_cause_o),
        .walk_valid_o(walk_valid_o), .walk_ready_i(walk_ready_i),
        .walk_spa_o(walk_spa_o), .walk_sdid_o(walk_sdid_o),
        .walk_done_i(walk_done_i), .walk_perm_i(walk_perm_i),
        .walk_fault_i(walk_fault_i), .walk_fault_cause_i(walk_fault_cause_i),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic [1:0] acc;
        logic [1:0] perm;
        logic       f;
        logic [2:0] c;
        logic       ea;
        logic [1:0] ep;
        logic       ef;
        logic [2:0] ec;
    } vec_t;

    int ncmp = 0;
    int nfail = 0;

    logic       h_allow;
    logic [1:0] h_perm;
    logic       h_fault;
    logic [2:0] h_cause;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic rule_allow(input logic [1:0] a, input logic [1:0] p, input logic f);
        if (f) return 1'b0;
        case (a)
            2'b00:   return 1'b1;
            2'b01:   return p != 2'b00;
            2'b10:   return (p == 2'b10) || (p == 2'b11);
            default: return (p == 2'b01) || (p == 2'b11);
        endcase
    endfunction

    task automatic chk_resp(input string nm);
        chk({nm, " allow"}, 64'(resp_allow_o), 64'(h_allow));
        chk({nm, " perm"}, 64'(resp_perm_o), 64'(h_perm));
        chk({nm, " fault"}, 64'(resp_fault_o), 64'(h_fault));
        chk({nm, " cause"}, 64'(resp_fault_cause_o), 64'(h_cause));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " ready"}, 64'(req_ready_o), 64'(0));
        chk({nm, " resp_valid"}, 64'(resp_valid_o), 64'(0));
        chk({nm, " walk_valid"}, 64'(walk_valid_o), 64'(0));
        chk({nm, " walk_spa"}, 64'(walk_spa_o), 64'(0));
        chk({nm, " walk_sdid"}, 64'(walk_sdid_o), 64'(0));
        chk({nm, " busy"}, 64'(busy_o), 64'(0));
        h_allow = 1'b0;
        h_perm  = 2'b00;
        h_fault = 1'b0;
        h_cause = 3'b000;
        chk_resp(nm);
    endtask

    task automatic idle_inputs();
        flush_i      = 1'b0;
        req_valid_i  = '0;
        walk_ready_i = 1'b0;
        walk_done_i  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        idle_inputs();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 chk_zero("reset");
    endtask

    // One isolated transaction on requester k with a given walker timing.
    task automatic run_txn(input int k, input logic [PL-1:0] spa, input logic [1:0] acc,
                           input logic [SL-1:0] sd, input logic [1:0] p, input logic f,
                           input logic [2:0] c, input int rd, input int dd,
                           input logic ea, input logic [1:0] ep, input logic ef,
                           input logic [2:0] ec, input string nm);
        @(negedge clk_i);
        req_valid_i = oh(k);
        req_spa_i[k*PL +: PL] = spa;
        req_access_i[k*2 +: 2] = acc;
        req_sdid_i = sd;
        #1 chk({nm, " ready"}, 64'(req_ready_o), 64'(oh(k)));
        for (int i = 0; i <= rd; i++) begin
            @(negedge clk_i);
            req_valid_i = '0;
            req_sdid_i = ~sd;
            walk_ready_i = (i == rd);
            #1;
            chk({nm, " walk_valid"}, 64'(walk_valid_o), 64'(1));
            chk({nm, " walk_spa"}, 64'(walk_spa_o), 64'(spa));
            chk({nm, " walk_sdid"}, 64'(walk_sdid_o), 64'(sd));
            chk({nm, " busy"}, 64'(busy_o), 64'(1));
        end
        for (int i = 0; i <= dd; i++) begin
            @(negedge clk_i);
            walk_ready_i = 1'b0;
            walk_done_i = (i == dd);
            walk_perm_i = (i == dd) ? p : 2'($urandom());
            walk_fault_i = (i == dd) ? f : 1'($urandom());
            walk_fault_cause_i = (i == dd) ? c : 3'($urandom());
            #1;
            chk({nm, " walk_valid"}, 64'(walk_valid_o), 64'(0));
            chk({nm, " early resp"}, 64'(resp_valid_o), 64'(0));
            chk_resp({nm, " held"});
        end
        @(negedge clk_i);
        walk_done_i = 1'b0;
        walk_perm_i = ~p;
        walk_fault_i = ~f;
        walk_fault_cause_i = ~c;
        #1;
        h_allow = ea;
        h_perm  = ep;
        h_fault = ef;
        h_cause = ec;
        chk({nm, " resp_valid"}, 64'(resp_valid_o), 64'(oh(k)));
        chk_resp(nm);
        @(negedge clk_i);
        #1;
        chk({nm, " pulse end"}, 64'(resp_valid_o), 64'(0));
        chk({nm, " idle"}, 64'(busy_o), 64'(0));
        chk_resp({nm, " hold"});
    endtask

    vec_t tbl [13];

    initial begin
        int rr, owner, gcyc, hs, dn, rsp, freec, w;
        logic [N-1:0] drop, ready_e, resp_e;
        logic [PL-1:0] o_spa;
        logic [SL-1:0] o_sd;
        logic [1:0] o_acc, o_p;
        logic o_f;
        logic [2:0] o_c;

        tbl[0]  = '{2'b01, 2'b10, 1'b0, 3'b000, 1'b1, 2'b10, 1'b0, 3'b000};
        tbl[1]  = '{2'b00, 2'b00, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 3'b000};
        tbl[2]  = '{2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 3'b000};
        tbl[3]  = '{2'b01, 2'b01, 1'b0, 3'b000, 1'b1, 2'b01, 1'b0, 3'b000};
        tbl[4]  = '{2'b10, 2'b01, 1'b0, 3'b000, 1'b0, 2'b01, 1'b0, 3'b000};
        tbl[5]  = '{2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 2'b10, 1'b0, 3'b000};
        tbl[6]  = '{2'b10, 2'b11, 1'b0, 3'b000, 1'b1, 2'b11, 1'b0, 3'b000};
        tbl[7]  = '{2'b11, 2'b10, 1'b0, 3'b000, 1'b0, 2'b10, 1'b0, 3'b000};
        tbl[8]  = '{2'b11, 2'b01, 1'b0, 3'b000, 1'b1, 2'b01, 1'b0, 3'b000};
        tbl[9]  = '{2'b11, 2'b11, 1'b0, 3'b000, 1'b1, 2'b11, 1'b0, 3'b000};
        tbl[10] = '{2'b01, 2'b11, 1'b1, 3'b011, 1'b0, 2'b00, 1'b1, 3'b011};
        tbl[11] = '{2'b00, 2'b10, 1'b1, 3'b101, 1'b0, 2'b00, 1'b1, 3'b101};
        tbl[12] = '{2'b10, 2'b10, 1'b0, 3'b110, 1'b1, 2'b10, 1'b0, 3'b000};

        rst_i = 1'b1;
        idle_inputs();
        req_valid_i = '1;
        req_spa_i = '0;
        req_access_i = '0;
        req_sdid_i = '0;
        walk_perm_i = '0;
        walk_fault_i = 1'b0;
        walk_fault_cause_i = '0;
        #1 chk("ready under reset", 64'(req_ready_o), 64'(0));
        do_reset();

        for (int i = 0; i < 13; i++) begin
            run_txn(i % N, (i == 0) ? 56'h0000_8000_1000 : PL'({$urandom(), $urandom()}),
                    tbl[i].acc, SL'(i + 5), tbl[i].perm, tbl[i].f, tbl[i].c,
                    i % 3, (i == 0) ? 1 : i % 4,
                    tbl[i].ea, tbl[i].ep, tbl[i].ef, tbl[i].ec, $sformatf("tbl%0d", i));
        end

        // Round robin with all requesters held valid.
        do_reset();
        req_access_i = {N{2'b01}};
        for (int t = 0; t < 4; t++) begin
            @(negedge clk_i);
            req_valid_i = '1;
            #1 chk($sformatf("rr grant%0d", t), 64'(req_ready_o), 64'(oh(t % N)));
            @(negedge clk_i);
            walk_ready_i = 1'b1;
            #1 chk("rr ready busy", 64'(req_ready_o), 64'(0));
            @(negedge clk_i);
            walk_ready_i = 1'b0;
            walk_done_i = 1'b1;
            walk_perm_i = 2'b10;
            walk_fault_i = 1'b0;
            #1 chk("rr ready wait", 64'(req_ready_o), 64'(0));
            @(negedge clk_i);
            walk_done_i = 1'b0;
            #1;
            h_allow = 1'b1;
            h_perm = 2'b10;
            h_fault = 1'b0;
            h_cause = 3'b000;
            chk($sformatf("rr resp%0d", t), 64'(resp_valid_o), 64'(oh(t % N)));
            chk_resp("rr");
        end
        @(negedge clk_i);
        req_valid_i = '0;

        // Flush in IDLE blocks the accept.
        @(negedge clk_i);
        req_valid_i = oh(0);
        flush_i = 1'b1;
        #1 chk("flush idle ready", 64'(req_ready_o), 64'(0));
        @(negedge clk_i);
        req_valid_i = '0;
        flush_i = 1'b0;
        #1 chk("flush idle busy", 64'(busy_o), 64'(0));

        // Flush in ISSUE drops the walk request.
        @(negedge clk_i);
        req_valid_i = oh(2);
        #1 chk("fi ready", 64'(req_ready_o), 64'(oh(2)));
        @(negedge clk_i);
        req_valid_i = '0;
        flush_i = 1'b1;
        walk_ready_i = 1'b1;
        #1 chk("fi walk_valid", 64'(walk_valid_o), 64'(0));
        @(negedge clk_i);
        flush_i = 1'b0;
        walk_ready_i = 1'b0;
        #1 chk("fi busy", 64'(busy_o), 64'(0));
        chk("fi resp", 64'(resp_valid_o), 64'(0));

        // Flush in first WAIT cycle, done four cycles later.
        @(negedge clk_i);
        req_valid_i = oh(1);
        #1 chk("fw ready", 64'(req_ready_o), 64'(oh(1)));
        @(negedge clk_i);
        req_valid_i = '0;
        walk_ready_i = 1'b1;
        #1 chk("fw walk_valid", 64'(walk_valid_o), 64'(1));
        @(negedge clk_i);
        walk_ready_i = 1'b0;
        flush_i = 1'b1;
        #1 chk("fw busy", 64'(busy_o), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            flush_i = 1'b0;
            #1 chk("fw still busy", 64'(busy_o), 64'(1));
        end
        @(negedge clk_i);
        walk_done_i = 1'b1;
        walk_perm_i = 2'b11;
        walk_fault_i = 1'b0;
        #1 chk("fw resp", 64'(resp_valid_o), 64'(0));
        @(negedge clk_i);
        walk_done_i = 1'b0;
        #1 chk("fw squashed", 64'(resp_valid_o), 64'(0));
        chk("fw idle", 64'(busy_o), 64'(0));
        chk_resp("fw held");
        run_txn(1, 56'h12_3456_789A, 2'b10, 6'h2A, 2'b11, 1'b0, 3'b000, 0, 0,
                1'b1, 2'b11, 1'b0, 3'b000, "after flush");

        // Flush and done in the same cycle.
        @(negedge clk_i);
        req_valid_i = oh(0);
        #1 chk("fd ready", 64'(req_ready_o), 64'(oh(0)));
        @(negedge clk_i);
        req_valid_i = '0;
        walk_ready_i = 1'b1;
        @(negedge clk_i);
        walk_ready_i = 1'b0;
        walk_done_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk_i);
        walk_done_i = 1'b0;
        flush_i = 1'b0;
        #1 chk("fd resp", 64'(resp_valid_o), 64'(0));
        chk("fd idle", 64'(busy_o), 64'(0));

        // Reset mid-walk: rr pointer must return to 0.
        run_txn(1, 56'h0F_0000_0040, 2'b01, 6'h11, 2'b01, 1'b0, 3'b000, 0, 0,
                1'b1, 2'b01, 1'b0, 3'b000, "pre reset");
        @(negedge clk_i);
        req_valid_i = oh(1);
        #1 chk("rm ready", 64'(req_ready_o), 64'(oh(1)));
        @(negedge clk_i);
        req_valid_i = '0;
        walk_ready_i = 1'b1;
        @(negedge clk_i);
        walk_ready_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 chk_zero("mid reset");
        @(negedge clk_i);
        walk_done_i = 1'b1;
        walk_perm_i = 2'b11;
        @(negedge clk_i);
        walk_done_i = 1'b0;
        #1 chk("late done resp", 64'(resp_valid_o), 64'(0));
        chk("late done busy", 64'(busy_o), 64'(0));
        @(negedge clk_i);
        req_valid_i = 3'b110;
        #1 chk("rr after reset", 64'(req_ready_o), 64'(oh(1)));

        // Random traffic against the timeline model.
        do_reset();
        rr = 0;
        owner = 0;
        gcyc = -100;
        hs = -100;
        dn = -100;
        rsp = -100;
        freec = 0;
        drop = '0;
        o_spa = '0;
        o_sd = '0;
        o_acc = '0;
        o_p = '0;
        o_f = 1'b0;
        o_c = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_i);
            req_valid_i = req_valid_i & ~drop;
            drop = '0;
            for (int k = 0; k < N; k++) begin
                if (!req_valid_i[k] && $urandom_range(0, 2) == 0) begin
                    req_valid_i[k] = 1'b1;
                    req_spa_i[k*PL +: PL] = PL'({$urandom(), $urandom()});
                    req_access_i[k*2 +: 2] = 2'($urandom());
                end
            end
            req_sdid_i = SL'($urandom());
            walk_ready_i = (n == hs);
            walk_done_i = (n == dn) ||
                          ((n <= hs || n > dn) && $urandom_range(0, 5) == 0);
            walk_perm_i = (n == dn) ? o_p : 2'($urandom());
            walk_fault_i = (n == dn) ? o_f : 1'($urandom());
            walk_fault_cause_i = (n == dn) ? o_c : 3'($urandom());
            #1;
            ready_e = '0;
            w = -1;
            if (n >= freec) begin
                for (int i = 0; i < N; i++) begin
                    if (w < 0 && req_valid_i[(rr + i) % N]) w = (rr + i) % N;
                end
                if (w >= 0) ready_e = oh(w);
            end
            resp_e = (n == rsp) ? oh(owner) : '0;
            if (n == rsp) begin
                h_allow = rule_allow(o_acc, o_p, o_f);
                h_perm  = o_f ? 2'b00 : o_p;
                h_fault = o_f;
                h_cause = o_f ? o_c : 3'b000;
            end
            chk("rnd ready", 64'(req_ready_o), 64'(ready_e));
            chk("rnd resp_valid", 64'(resp_valid_o), 64'(resp_e));
            chk("rnd busy", 64'(busy_o), 64'(n > gcyc && n < freec));
            chk("rnd walk_valid", 64'(walk_valid_o), 64'(n > gcyc && n <= hs));
            if (n > gcyc && n <= hs) begin
                chk("rnd walk_spa", 64'(walk_spa_o), 64'(o_spa));
                chk("rnd walk_sdid", 64'(walk_sdid_o), 64'(o_sd));
            end
            chk_resp("rnd");
            if (w >= 0) begin
                owner = w;
                rr = (w + 1) % N;
                gcyc = n;
                hs = n + 1 + $urandom_range(0, 3);
                dn = hs + 1 + $urandom_range(0, 3);
                rsp = dn + 1;
                freec = rsp + 1;
                o_spa = req_spa_i[w*PL +: PL];
                o_acc = req_access_i[w*2 +: 2];
                o_sd = req_sdid_i;
                o_p = 2'($urandom());
                o_f = ($urandom_range(0, 3) == 0);
                o_c = 3'($urandom());
                drop = oh(w);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/mpt_walk_arbiter.md
Name: mpt_walk_arbiter

Overview:
- Shares one Memory Protection Table walker between NUM_REQ requesters, e.g. fetch, load/store and the MMU page-table walker.
- Requesters are served in round-robin order, with one walk outstanding at a time.
- The block captures the walker result and checks the requested access type against the returned 2-bit permission.
- It returns a per-requester response pulse with an allow/fault verdict.
- It sits between the core-side MPT check points and the MPT lookup FSM.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 has first priority after reset.
- PLEN, 56, supervisor physical address width (34 for RV32).
- SDID_LEN, 6, supervisor domain identifier width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  abort the current transaction and suppress its response.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_spa_i  in  NUM_REQ*PLEN  packed request addresses; requester k occupies [k*PLEN +: PLEN].
- req_access_i  in  NUM_REQ*2  packed access types: 00 none, 01 read, 10 write, 11 exec.
- req_sdid_i  in  SDID_LEN  current supervisor domain ID, sampled at accept.
- resp_valid_o  out  NUM_REQ  one-cycle response pulse to the owning requester.
- resp_allow_o  out  1  access permitted.
- resp_perm_o  out  2  permission returned by the walker: 00 disallowed, 01 RX, 10 RW, 11 RWX.
- resp_fault_o  out  1  walker reported a format/access fault.
- resp_fault_cause_o  out  3  fault code from the walker; 000 when there is no fault.
- walk_valid_o  out  1  walk request to the walker.
- walk_ready_i  in  1  walker accepts the request.
- walk_spa_o  out  PLEN  address to walk.
- walk_sdid_o  out  SDID_LEN  domain ID of the walk.
- walk_done_i  in  1  walker result valid (single-cycle pulse).
- walk_perm_i  in  2  walker permission.
- walk_fault_i  in  1  walker fault.
- walk_fault_cause_i  in  3  walker fault cause.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE, rr_ptr=0. All outputs 0: req_ready_o, resp_valid_o, resp_allow_o, resp_perm_o, resp_fault_o, resp_fault_cause_o, walk_valid_o, walk_spa_o, walk_sdid_o, busy_o. Reset overrides all other inputs, including mid-walk; a walk_done_i arriving afterwards is ignored in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g = first index with req_valid_i set, searching from rr_ptr upward with wrap-around.
  - req_ready_o[g]=1 combinationally in the same cycle. This is the accept cycle.
  - On accept: latch spa, access, sdid and g; set rr_ptr=(g+1) mod NUM_REQ; go to ISSUE.
  - If flush_i is high in IDLE, no accept occurs (req_ready_o=0).
- ISSUE:
  - walk_valid_o=1, with walk_spa_o and walk_sdid_o driven from the latches and held stable.
  - On walk_ready_i, go to WAIT.
  - If flush_i is high before the handshake: drop walk_valid_o, go to IDLE, no response.
- WAIT:
  - On walk_done_i: latch perm, fault and cause; go to RESP.
  - If flush_i is high: set the squash flag and keep waiting for walk_done_i. On done, go to IDLE with no response; squash clears.
  - flush_i and walk_done_i in the same cycle is treated as squashed.
- RESP:
  - resp_valid_o[g]=1 for exactly one cycle; go to IDLE.
  - resp_* outputs are registered and hold their values until the next RESP.
  - flush_i in RESP does not cancel the pulse.
- Allow rule:
  - fault → allow=0, perm=00.
  - Otherwise: none → allow=1; read → perm≠00; write → perm∈{10,11}; exec → perm∈{01,11}.
- Latency: accept to resp_valid_o is 3 cycles plus walker ready wait plus walker done wait. Minimum is 3 cycles, with ready in ISSUE and done in the first WAIT cycle.
- Throughput: the earliest next accept is the IDLE cycle after RESP.
- Requesters must hold valid, spa and access until accepted. A deasserting requester is not granted.
- walk_done_i outside WAIT is ignored.

Test Plan:
- Single read: req 0 at spa 0x0000_8000_1000, walker perm 10 with done 2 cycles after ready → resp_valid_o[0] pulses 1 cycle; allow=1, perm=10, fault=0.
- Round-robin: requesters 0, 1 and 2 held valid continuously → grants in order 0,1,2,0; no requester is granted twice while another is waiting.
- Exec on RW: access 11, perm 10 → allow=0, fault=0; then exec with perm 01 → allow=1.
- Fault: walk_fault_i=1 with cause 011 → fault=1, cause=011, allow=0, perm=00.
- Flush in WAIT: flush_i in the cycle after the walk handshake, done 4 cycles later → no resp_valid_o; returns to IDLE; the next request is granted normally.
- Reset mid-walk: rst_i asserted in WAIT → all outputs 0 the next cycle, rr_ptr=0, and a late walk_done_i produces no response.
